// File: rtl/ddr_rw_arbiter_pkg.sv
// Shared constants and sizing helpers for the DDR arbiter LSRAM FIFO controller.
package ddr_rw_arbiter_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_ADDR_WIDTH  = 7;
   localparam int unsigned RAM_DEPTH       = 2 ** DEF_ADDR_WIDTH;
   localparam int unsigned DEF_AFULL_LEVEL = RAM_DEPTH - 8;

   function automatic int unsigned ram_depth(input int unsigned addr_w);
      return 2 ** addr_w;
   endfunction

   // RAM words plus one in-flight read plus two output-buffer entries.
   function automatic int unsigned count_width(input int unsigned addr_w);
      return $clog2(ram_depth(addr_w) + 3);
   endfunction

endpackage

// File: rtl/ddr_rw_arbiter_out_skid2.sv
// Two-entry first-word-fall-through output buffer (head + skid) fed by RAM read data.
module ddr_rw_arbiter_out_skid2
   import ddr_rw_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  head_valid_o,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic [1:0]            buf_cnt_o
);

   logic                  head_valid_q, head_valid_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

   always_comb begin
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (pop_i) begin
         head_valid_d = skid_valid_q;
         head_data_d  = skid_data_q;
         skid_valid_d = 1'b0;
      end
      // Push lands in the first entry still free after this cycle's pop.
      if (push_i) begin
         if (!head_valid_d) begin
            head_valid_d = 1'b1;
            head_data_d  = push_data_i;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = push_data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         head_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         head_data_q  <= head_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign head_valid_o = head_valid_q;
   assign head_data_o  = head_data_q;
   assign buf_cnt_o    = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/ddr_rw_arbiter_lsram_fifo_ctrl.sv
// FIFO controller in front of an external LSRAM: valid/ready write stream in,
// FWFT valid/ready read stream out, sustaining one word per cycle each way.
module ddr_rw_arbiter_lsram_fifo_ctrl
   import ddr_rw_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned AFULL_LEVEL = DEF_AFULL_LEVEL
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_VALID,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  WR_READY,
   output logic                  RD_VALID,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   input  logic                  RD_READY,
   output logic [ADDR_WIDTH+1:0] COUNT,
   output logic                  ALMOST_FULL,
   output logic [DATA_WIDTH-1:0] RAM_W_DATA,
   output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
   output logic                  RAM_W_EN,
   output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
   output logic                  RAM_R_EN,
   input  logic [DATA_WIDTH-1:0] RAM_R_DATA
);

   localparam int unsigned RamDepth = ram_depth(ADDR_WIDTH);
   localparam int unsigned CntW     = count_width(ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  afull_q, afull_d;

   logic                  wr_fire, rd_fire, rd_issue, ram_full;
   logic [1:0]            buf_cnt;
   logic [2:0]            occ;
   logic                  head_valid;
   logic [DATA_WIDTH-1:0] head_data;

   assign ram_full = (ram_cnt_q == (ADDR_WIDTH+1)'(RamDepth));
   assign WR_READY = ~ram_full & ~RST;
   assign wr_fire  = WR_VALID & WR_READY;
   assign rd_fire  = head_valid & RD_READY;

   // Buffer slots already spoken for once this cycle's pop is applied.
   assign occ      = {1'b0, buf_cnt} + {2'b00, rd_pend_q} - {2'b00, rd_fire};
   // ram_cnt_q excludes this cycle's write, so a read never hits the write address.
   assign rd_issue = (ram_cnt_q != '0) && (occ < 3'd2) && !RST;

   always_comb begin
      wptr_d    = wptr_q + ADDR_WIDTH'(wr_fire);
      rptr_d    = rptr_q + ADDR_WIDTH'(rd_issue);
      ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(wr_fire) - (ADDR_WIDTH+1)'(rd_issue);
      rd_pend_d = rd_issue;
      count_d   = count_q + CntW'(wr_fire) - CntW'(rd_fire);
      afull_d   = (32'(count_d) >= AFULL_LEVEL);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ram_cnt_q <= '0;
         rd_pend_q <= 1'b0;
         count_q   <= '0;
         afull_q   <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ram_cnt_q <= ram_cnt_d;
         rd_pend_q <= rd_pend_d;
         count_q   <= count_d;
         afull_q   <= afull_d;
      end
   end

   ddr_rw_arbiter_out_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_skid2 (
      .clk_i        (CLK),
      .rst_i        (RST),
      .push_i       (rd_pend_q),
      .push_data_i  (RAM_R_DATA),
      .pop_i        (rd_fire),
      .head_valid_o (head_valid),
      .head_data_o  (head_data),
      .buf_cnt_o    (buf_cnt)
   );

   assign RAM_W_EN    = wr_fire;
   assign RAM_W_ADDR  = wptr_q;
   assign RAM_W_DATA  = WR_DATA;
   assign RAM_R_EN    = rd_issue;
   assign RAM_R_ADDR  = rptr_q;
   assign RD_VALID    = head_valid;
   assign RD_DATA     = head_data;
   assign COUNT       = (ADDR_WIDTH+2)'(count_q);
   assign ALMOST_FULL = afull_q;

endmodule

// File: tb/tb_ddr_rw_arbiter_lsram_fifo_ctrl.sv
// Directed bench for the LSRAM FIFO controller with a behavioural 1-cycle-read RAM.
module tb_ddr_rw_arbiter_lsram_fifo_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        WR_VALID = 1'b0;
   logic [31:0] WR_DATA = '0;
   logic        WR_READY;
   logic        RD_VALID;
   logic [31:0] RD_DATA;
   logic        RD_READY = 1'b0;
   logic [8:0]  COUNT;
   logic        ALMOST_FULL;
   logic [31:0] RAM_W_DATA;
   logic [6:0]  RAM_W_ADDR;
   logic        RAM_W_EN;
   logic [6:0]  RAM_R_ADDR;
   logic        RAM_R_EN;
   logic [31:0] RAM_R_DATA;

   logic [31:0] mem [128];
   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RAM_W_EN) mem[RAM_W_ADDR] <= RAM_W_DATA;
      if (RAM_R_EN) RAM_R_DATA <= mem[RAM_R_ADDR];
   end

   ddr_rw_arbiter_lsram_fifo_ctrl #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (7),
      .AFULL_LEVEL (120)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .WR_VALID    (WR_VALID),
      .WR_DATA     (WR_DATA),
      .WR_READY    (WR_READY),
      .RD_VALID    (RD_VALID),
      .RD_DATA     (RD_DATA),
      .RD_READY    (RD_READY),
      .COUNT       (COUNT),
      .ALMOST_FULL (ALMOST_FULL),
      .RAM_W_DATA  (RAM_W_DATA),
      .RAM_W_ADDR  (RAM_W_ADDR),
      .RAM_W_EN    (RAM_W_EN),
      .RAM_R_ADDR  (RAM_R_ADDR),
      .RAM_R_EN    (RAM_R_EN),
      .RAM_R_DATA  (RAM_R_DATA)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: RD_READY toggles every 3 cycles, random WR_VALID.
   // mode 1: at most 5 words outstanding, random RD_READY.
   task automatic traffic(input int mode, input int n_words);
      logic [31:0] q[$];
      logic [31:0] data_prev;
      logic        stall_prev;
      int wr_n;
      int rd_n;
      int cyc;
      wr_n = 0;
      rd_n = 0;
      cyc = 0;
      stall_prev = 1'b0;
      data_prev = '0;
      while (rd_n < n_words && cyc < 20000) begin
         if (mode == 0) begin
            RD_READY = ((cyc / 3) % 2) == 0;
            WR_VALID = (wr_n < n_words) && ($urandom_range(1, 0) == 1);
         end else begin
            RD_READY = $urandom_range(1, 0) == 1;
            WR_VALID = (wr_n < n_words) && ((wr_n - rd_n) < 5);
         end
         WR_DATA = $urandom;
         #1;
         if (stall_prev) begin
            chk("stall_valid", RD_VALID, 1'b1);
            chk("stall_data", RD_DATA, data_prev);
         end
         if (WR_VALID && WR_READY) begin
            q.push_back(WR_DATA);
            wr_n++;
         end
         if (RD_VALID && RD_READY) begin
            chk("pop_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) chk(mode == 0 ? "bp_data" : "wrap_data", RD_DATA, q.pop_front());
            rd_n++;
         end
         stall_prev = RD_VALID && !RD_READY;
         data_prev = RD_DATA;
         tick();
         cyc++;
      end
      WR_VALID = 1'b0;
      RD_READY = 1'b0;
      chk("traffic_words_out", rd_n, n_words);
      chk("traffic_queue_empty", q.size(), 0);
      #1;
      chk("traffic_count_zero", COUNT, 9'd0);
      chk("traffic_no_extra", RD_VALID, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tally;
      int k;
      int wr_idx;
      int rd_idx;
      int bubbles;
      int maxcnt;

      // Reset state
      repeat (3) tick();
      #1;
      chk("rst_wr_ready", WR_READY, 1'b0);
      chk("rst_rd_valid", RD_VALID, 1'b0);
      chk("rst_rd_data", RD_DATA, 32'h0);
      chk("rst_count", COUNT, 9'd0);
      chk("rst_afull", ALMOST_FULL, 1'b0);
      chk("rst_ram_r_en", RAM_R_EN, 1'b0);
      RST = 1'b0;
      #1;
      chk("post_rst_wr_ready", WR_READY, 1'b1);

      // Single word latency
      WR_VALID = 1'b1;
      WR_DATA = 32'hA5A5_0001;
      #1;
      chk("single_w_en", RAM_W_EN, 1'b1);
      chk("single_w_addr", RAM_W_ADDR, 7'd0);
      chk("single_w_data", RAM_W_DATA, 32'hA5A5_0001);
      tick();
      WR_VALID = 1'b0;
      #1;
      chk("single_r_en", RAM_R_EN, 1'b1);
      chk("single_r_addr", RAM_R_ADDR, 7'd0);
      chk("single_count1", COUNT, 9'd1);
      chk("single_valid_n1", RD_VALID, 1'b0);
      tick();
      chk("single_r_en_off", RAM_R_EN, 1'b0);
      chk("single_valid_n2", RD_VALID, 1'b0);
      tick();
      chk("single_valid_n3", RD_VALID, 1'b1);
      chk("single_data", RD_DATA, 32'hA5A5_0001);
      chk("single_count_held", COUNT, 9'd1);
      RD_READY = 1'b1;
      tick();
      RD_READY = 1'b0;
      #1;
      chk("single_popped_valid", RD_VALID, 1'b0);
      chk("single_popped_count", COUNT, 9'd0);

      // Fill with no reads
      tally = 0;
      for (int i = 0; i < 200; i++) begin
         WR_VALID = 1'b1;
         WR_DATA = 32'hF000_0000 + tally;
         #1;
         chk("fill_count", COUNT, tally);
         chk("fill_afull", ALMOST_FULL, tally >= 120);
         if (WR_READY) tally++;
         tick();
      end
      WR_VALID = 1'b0;
      #1;
      chk("fill_accepted", tally, 130);
      chk("fill_wr_ready", WR_READY, 1'b0);
      chk("fill_count_final", COUNT, 9'd130);
      chk("fill_afull_final", ALMOST_FULL, 1'b1);

      // Drain
      k = 0;
      RD_READY = 1'b1;
      for (int i = 0; i < 300 && k < 130; i++) begin
         #1;
         if (RD_VALID) begin
            chk("drain_data", RD_DATA, 32'hF000_0000 + k);
            k++;
         end
         tick();
      end
      RD_READY = 1'b0;
      #1;
      chk("drain_words", k, 130);
      chk("drain_count", COUNT, 9'd0);
      chk("drain_afull", ALMOST_FULL, 1'b0);

      // Streaming 0..999
      wr_idx = 0;
      rd_idx = 0;
      bubbles = 0;
      maxcnt = 0;
      for (int c = 0; c < 2000 && rd_idx < 1000; c++) begin
         WR_VALID = wr_idx < 1000;
         WR_DATA = wr_idx;
         RD_READY = 1'b1;
         #1;
         if (int'(COUNT) > maxcnt) maxcnt = int'(COUNT);
         if (rd_idx > 0 && !RD_VALID) bubbles++;
         if (WR_VALID && WR_READY) wr_idx++;
         if (RD_VALID) begin
            chk("stream_data", RD_DATA, rd_idx);
            rd_idx++;
         end
         tick();
      end
      WR_VALID = 1'b0;
      RD_READY = 1'b0;
      chk("stream_words", rd_idx, 1000);
      chk("stream_bubbles", bubbles, 0);
      chk("stream_maxcnt_le3", maxcnt <= 3, 1'b1);

      // Backpressure and wrap
      traffic(0, 200);
      traffic(1, 300);

      // Reset mid-stream with a read in flight
      for (int i = 0; i < 51; i++) begin
         WR_VALID = 1'b1;
         WR_DATA = 32'hBEEF_0000 + i;
         tick();
      end
      WR_VALID = 1'b0;
      repeat (4) tick();
      chk("mid_count51", COUNT, 9'd51);
      RD_READY = 1'b1;
      #1;
      chk("mid_issue", RAM_R_EN, 1'b1);
      tick();
      RD_READY = 1'b0;
      #1;
      chk("mid_count50", COUNT, 9'd50);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      chk("mid_rst_valid", RD_VALID, 1'b0);
      chk("mid_rst_count", COUNT, 9'd0);
      chk("mid_rst_wr_ready", WR_READY, 1'b1);
      chk("mid_rst_afull", ALMOST_FULL, 1'b0);
      WR_VALID = 1'b1;
      WR_DATA = 32'h0000_1234;
      tick();
      WR_VALID = 1'b0;
      RD_READY = 1'b1;
      for (int i = 0; i < 10 && !RD_VALID; i++) tick();
      chk("mid_first_valid", RD_VALID, 1'b1);
      chk("mid_first_data", RD_DATA, 32'h0000_1234);
      tick();
      RD_READY = 1'b0;
      #1;
      chk("mid_after_valid", RD_VALID, 1'b0);
      chk("mid_after_count", COUNT, 9'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
